// File: rtl/vector_checker.sv
// Self-checking test-vector engine: replays stored {stim, exp, mask} vectors into a DUT
// and compares the response after a fixed latency, counting and capturing mismatches.
module vector_checker #(
   parameter int IN_W   = 3,
   parameter int OUT_W  = 1,
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8,
   parameter int LAT    = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load_en,
   input  logic [ADDR_W-1:0]       load_addr,
   input  logic [IN_W+2*OUT_W-1:0] load_data,
   input  logic [ADDR_W:0]         num_vec,
   input  logic                    start,
   input  logic                    stop_on_err,
   output logic [IN_W-1:0]         dut_in,
   input  logic [OUT_W-1:0]        dut_out,
   output logic                    busy,
   output logic                    done,
   output logic                    pass,
   output logic                    err_pulse,
   output logic [15:0]             err_count,
   output logic [ADDR_W:0]         vec_count,
   output logic [ADDR_W-1:0]       first_err_idx,
   output logic [OUT_W-1:0]        first_err_got
);

   localparam int VW = IN_W + 2*OUT_W;
   localparam logic [ADDR_W:0] DEPTH_V = DEPTH[ADDR_W:0];
   localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t state_q, state_d;

   logic [VW-1:0]     vec_mem [DEPTH];
   logic [VW-1:0]     rd_vec;
   logic              mem_we;
   logic [ADDR_W:0]   ptr_q, ptr_d;
   logic [ADDR_W:0]   nv_q, nv_d;
   logic              stop_q, stop_d;
   logic [IN_W-1:0]   dut_in_q, dut_in_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic              err_pulse_q, err_pulse_d;
   logic [15:0]       err_count_q, err_count_d;
   logic [ADDR_W:0]   vec_count_q, vec_count_d;
   logic [ADDR_W-1:0] first_err_idx_q, first_err_idx_d;
   logic [OUT_W-1:0]  first_err_got_q, first_err_got_d;
   logic [LAT:0]      vld_q, vld_d;
   logic [OUT_W-1:0]  exp_q  [LAT+1];
   logic [OUT_W-1:0]  exp_d  [LAT+1];
   logic [OUT_W-1:0]  mask_q [LAT+1];
   logic [OUT_W-1:0]  mask_d [LAT+1];
   logic              cmp_vld;
   logic              mismatch;

   assign mem_we   = load_en && (state_q == IDLE || state_q == DONE) && ({1'b0, load_addr} < DEPTH_V);
   assign rd_vec   = vec_mem[ptr_q[ADDR_W-1:0]];
   assign cmp_vld  = vld_q[LAT];
   assign mismatch = |((dut_out ^ exp_q[LAT]) & mask_q[LAT]);

   // Vector memory has no reset so loaded vectors survive a reset and can be replayed.
   always_ff @(posedge clk) begin
      if (mem_we) vec_mem[load_addr] <= load_data;
   end

   always_comb begin
      state_d         = state_q;
      ptr_d           = ptr_q;
      nv_d            = nv_q;
      stop_d          = stop_q;
      dut_in_d        = dut_in_q;
      busy_d          = (state_q == RUN) || (state_q == DRAIN);
      done_d          = (state_q == DONE);
      pass_d          = (state_q == DONE) && (err_count_q == 16'd0);
      err_pulse_d     = 1'b0;
      err_count_d     = err_count_q;
      vec_count_d     = vec_count_q;
      first_err_idx_d = first_err_idx_q;
      first_err_got_d = first_err_got_q;
      vld_d           = '0;
      exp_d[0]        = exp_q[0];
      mask_d[0]       = mask_q[0];
      for (int k = 1; k <= LAT; k++) begin
         vld_d[k]  = vld_q[k-1];
         exp_d[k]  = exp_q[k-1];
         mask_d[k] = mask_q[k-1];
      end

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               nv_d            = (num_vec > DEPTH_V) ? DEPTH_V : num_vec;
               stop_d          = stop_on_err;
               ptr_d           = '0;
               err_count_d     = '0;
               vec_count_d     = '0;
               first_err_idx_d = '0;
               first_err_got_d = '0;
               vld_d           = '0;
               state_d         = (nv_d == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            dut_in_d  = rd_vec[VW-1 -: IN_W];
            exp_d[0]  = rd_vec[2*OUT_W-1 -: OUT_W];
            mask_d[0] = rd_vec[OUT_W-1:0];
            vld_d[0]  = 1'b1;
            ptr_d     = ptr_q + CNT_ONE;
            if (ptr_d == nv_q) state_d = DRAIN;
         end
         default: ;
      endcase

      // vec_count doubles as the index of the vector being compared.
      if ((state_q == RUN || state_q == DRAIN) && cmp_vld) begin
         vec_count_d = vec_count_q + CNT_ONE;
         if (mismatch) begin
            err_pulse_d = 1'b1;
            if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
            if (err_count_q == 16'd0) begin
               first_err_idx_d = vec_count_q[ADDR_W-1:0];
               first_err_got_d = dut_out;
            end
            if (stop_q) begin
               state_d = DONE;
               vld_d   = '0;
            end
         end
         if (vec_count_d == nv_q) begin
            state_d = DONE;
            vld_d   = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q         <= IDLE;
         ptr_q           <= '0;
         nv_q            <= '0;
         stop_q          <= 1'b0;
         dut_in_q        <= '0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         pass_q          <= 1'b0;
         err_pulse_q     <= 1'b0;
         err_count_q     <= '0;
         vec_count_q     <= '0;
         first_err_idx_q <= '0;
         first_err_got_q <= '0;
         vld_q           <= '0;
      end else begin
         state_q         <= state_d;
         ptr_q           <= ptr_d;
         nv_q            <= nv_d;
         stop_q          <= stop_d;
         dut_in_q        <= dut_in_d;
         busy_q          <= busy_d;
         done_q          <= done_d;
         pass_q          <= pass_d;
         err_pulse_q     <= err_pulse_d;
         err_count_q     <= err_count_d;
         vec_count_q     <= vec_count_d;
         first_err_idx_q <= first_err_idx_d;
         first_err_got_q <= first_err_got_d;
         vld_q           <= vld_d;
      end
   end

   // Expected/mask pipeline data is qualified by vld_q, so it needs no reset.
   always_ff @(posedge clk) begin
      exp_q  <= exp_d;
      mask_q <= mask_d;
   end

   assign dut_in        = dut_in_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign pass          = pass_q;
   assign err_pulse     = err_pulse_q;
   assign err_count     = err_count_q;
   assign vec_count     = vec_count_q;
   assign first_err_idx = first_err_idx_q;
   assign first_err_got = first_err_got_q;

endmodule

// File: tb/tb_vector_checker.sv
// Scoreboard bench for vector_checker driving a two-register-latency reference DUT
// (y = ~b&~c | a&~b) with directed and randomized vector sets.
module tb_vector_checker;

   localparam int IN_W   = 3;
   localparam int OUT_W  = 1;
   localparam int DEPTH  = 256;
   localparam int ADDR_W = 8;
   localparam int LAT    = 2;

   typedef struct {
      int idx;
      int ord;
   } err_t;

   typedef struct {
      int errs;
      int vcnt;
      bit pass;
      int fidx;
      int fgot;
      int done_cyc;
      bit chk_stim;
      int last_stim;
   } res_t;

   logic                    clk = 1'b0;
   logic                    reset = 1'b0;
   logic                    load_en = 1'b0;
   logic [ADDR_W-1:0]       load_addr = '0;
   logic [IN_W+2*OUT_W-1:0] load_data = '0;
   logic [ADDR_W:0]         num_vec = '0;
   logic                    start = 1'b0;
   logic                    stop_on_err = 1'b0;
   logic [IN_W-1:0]         dut_in;
   logic [OUT_W-1:0]        dut_out;
   logic                    busy, done, pass, err_pulse;
   logic [15:0]             err_count;
   logic [ADDR_W:0]         vec_count;
   logic [ADDR_W-1:0]       first_err_idx;
   logic [OUT_W-1:0]        first_err_got;
   logic [OUT_W-1:0]        pipe1 = '0;
   logic [OUT_W-1:0]        pipe2 = '0;

   logic [IN_W-1:0] m_stim [DEPTH];
   logic            m_exp  [DEPTH];
   logic            m_mask [DEPTH];

   err_t err_q[$];
   res_t res_q[$];
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   vector_checker #(
      .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LAT(LAT)
   ) u_dut (
      .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .num_vec(num_vec), .start(start),
      .stop_on_err(stop_on_err), .dut_in(dut_in), .dut_out(dut_out),
      .busy(busy), .done(done), .pass(pass), .err_pulse(err_pulse),
      .err_count(err_count), .vec_count(vec_count),
      .first_err_idx(first_err_idx), .first_err_got(first_err_got)
   );

   always #5 clk = ~clk;

   function automatic logic ref_fn(input logic [2:0] v);
      logic a, b, c;
      a = v[2];
      b = v[1];
      c = v[0];
      return (!b && !c) || (a && !b);
   endfunction

   // Device under test: combinational function followed by two registers (LAT = 2).
   always @(posedge clk) begin
      pipe1 <= ref_fn(dut_in);
      pipe2 <= pipe1;
   end
   assign dut_out = pipe2;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("[TB] FAIL %s got=%0d want=%0d (cycle %0d)", name, got, want, cyc);
      end
   endtask

   task automatic check_reset();
      check_output("rst_dut_in", int'(dut_in), 0);
      check_output("rst_busy", int'(busy), 0);
      check_output("rst_done", int'(done), 0);
      check_output("rst_pass", int'(pass), 0);
      check_output("rst_err_pulse", int'(err_pulse), 0);
      check_output("rst_err_count", int'(err_count), 0);
      check_output("rst_vec_count", int'(vec_count), 0);
      check_output("rst_first_idx", int'(first_err_idx), 0);
      check_output("rst_first_got", int'(first_err_got), 0);
   endtask

   task automatic load_vec(input int a, input int s, input int e, input int m);
      load_en   = 1'b1;
      load_addr = ADDR_W'(a);
      load_data = {IN_W'(s), 1'(e), 1'(m)};
      @(posedge clk);
      @(negedge clk);
      load_en = 1'b0;
      m_stim[a] = IN_W'(s);
      m_exp[a]  = 1'(e);
      m_mask[a] = 1'(m);
   endtask

   // Predict the whole run from the vector table, queue expectations, then issue start.
   task automatic apply_stimulus(input int num, input bit stop);
      int   nv, errs, s, t;
      bit   stopped;
      res_t r;
      err_t e;
      r = '{default: 0};
      nv = (num > DEPTH) ? DEPTH : num;
      errs = 0;
      s = 0;
      stopped = 1'b0;
      for (int i = 0; i < nv; i++) begin
         logic got;
         got = ref_fn(m_stim[i]);
         r.vcnt = i + 1;
         if (((got ^ m_exp[i]) & m_mask[i]) != 1'b0) begin
            errs++;
            e.idx = i;
            e.ord = errs;
            err_q.push_back(e);
            if (errs == 1) begin
               r.fidx = i;
               r.fgot = int'(got);
            end
            if (stop) begin
               stopped = 1'b1;
               s = i;
               break;
            end
         end
      end
      t = cyc + 1;
      if (nv == 0) r.done_cyc = t + 1;
      else if (stopped) r.done_cyc = t + 3 + s + LAT;
      else r.done_cyc = t + nv + LAT + 2;
      r.errs = errs;
      r.pass = (errs == 0);
      r.chk_stim = (nv > 0) && !stopped;
      if (nv > 0) r.last_stim = int'(m_stim[nv-1]);
      res_q.push_back(r);
      num_vec     = num[ADDR_W:0];
      stop_on_err = stop;
      start       = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Wait for the monitor to retire the run; optionally attempt a corrupting write mid-run.
   task automatic wait_run(input int num, input bit scribble);
      int nv, k, budget;
      nv = (num > DEPTH) ? DEPTH : num;
      budget = nv + LAT + 20;
      k = 0;
      while (res_q.size() > 0 && k < budget) begin
         if (scribble && k < 3 && nv >= 4) begin
            load_en   = 1'b1;
            load_addr = ADDR_W'(nv - 1);
            load_data = {m_stim[nv-1], ~m_exp[nv-1], 1'b1};
         end else begin
            load_en = 1'b0;
         end
         @(posedge clk);
         @(negedge clk);
         k++;
         if (k == 1) check_output("busy_after_start", int'(busy), (nv > 0) ? 1 : 0);
      end
      load_en = 1'b0;
      check_output("run_complete", res_q.size(), 0);
      res_q.delete();
      err_q.delete();
   endtask

   // Monitor: retires error strobes and run completions against queued expectations.
   initial begin
      bit   prev_done;
      err_t e;
      res_t r;
      prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (err_pulse) begin
            if (err_q.size() == 0) begin
               check_output("err_pulse_unexpected", 1, 0);
            end else begin
               e = err_q.pop_front();
               check_output("err_idx", int'(vec_count) - 1, e.idx);
               check_output("err_count_step", int'(err_count), e.ord);
            end
         end
         if (done && !prev_done) begin
            if (res_q.size() == 0) begin
               check_output("done_unexpected", 1, 0);
            end else begin
               r = res_q.pop_front();
               check_output("done_cycle", cyc, r.done_cyc);
               check_output("err_count", int'(err_count), r.errs);
               check_output("vec_count", int'(vec_count), r.vcnt);
               check_output("pass", int'(pass), int'(r.pass));
               check_output("first_err_idx", int'(first_err_idx), r.fidx);
               check_output("first_err_got", int'(first_err_got), r.fgot);
               check_output("missing_err_pulses", err_q.size(), 0);
               if (r.chk_stim) check_output("dut_in_hold", int'(dut_in), r.last_stim);
            end
         end
         prev_done = done;
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [7:0] tt;
      tt = 8'b0011_0001;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset();
      reset = 1'b1;

      for (int i = 0; i < 8; i++) load_vec(i, i, int'(tt[i]), 1);

      $display("[TB] empty run and clean truth table");
      apply_stimulus(0, 1'b0);
      wait_run(0, 1'b0);
      apply_stimulus(8, 1'b0);
      wait_run(8, 1'b0);

      $display("[TB] corrupted expectations at 3 and 6");
      load_vec(3, 3, int'(!tt[3]), 1);
      load_vec(6, 6, int'(!tt[6]), 1);
      apply_stimulus(8, 1'b0);
      wait_run(8, 1'b0);
      apply_stimulus(8, 1'b1);
      wait_run(8, 1'b0);

      $display("[TB] masked-out mismatch");
      load_vec(6, 6, int'(tt[6]), 1);
      load_vec(3, 3, int'(!tt[3]), 0);
      apply_stimulus(8, 1'b0);
      wait_run(8, 1'b0);

      $display("[TB] reset mid-run then replay");
      apply_stimulus(8, 1'b0);
      repeat (4) begin
         @(posedge clk);
         @(negedge clk);
      end
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      res_q.delete();
      err_q.delete();
      reset = 1'b1;
      check_reset();
      apply_stimulus(8, 1'b0);
      wait_run(8, 1'b0);

      $display("[TB] num_vec beyond depth");
      for (int a = 0; a < DEPTH; a++) begin
         int s;
         s = $urandom_range(0, 7);
         load_vec(a, s, int'(ref_fn(IN_W'(s))) ^ int'($urandom_range(0, 15) == 0), $urandom_range(0, 1));
      end
      apply_stimulus(300, 1'b0);
      wait_run(300, 1'b0);

      $display("[TB] random runs with writes attempted while busy");
      for (int r = 0; r < 8; r++) begin
         int n;
         n = $urandom_range(4, 64);
         for (int a = 0; a < n; a++) begin
            int s;
            s = $urandom_range(0, 7);
            load_vec(a, s, int'(ref_fn(IN_W'(s))) ^ int'($urandom_range(0, 7) == 0), $urandom_range(0, 1));
         end
         apply_stimulus(n, 1'($urandom_range(0, 1)));
         wait_run(n, 1'b1);
      end

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
